// File: rtl/fetch_queue_pkg.sv
// Shared defaults for the fetch queue: datapath widths, depth and the NOP packet shown to decode.
// The NOP packet (addi x0,x0,0 with zero PC/nPC and no commit) is what decode sees while the queue is empty.
package fetch_queue_pkg;

  localparam int unsigned FQ_INSTR_WIDTH = 32;
  localparam int unsigned FQ_PC_WIDTH    = 32;
  localparam int unsigned FQ_DEPTH       = 4;

  localparam logic [31:0] FQ_NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] FQ_NOP_PC     = 32'h0000_0000;
  localparam logic [31:0] FQ_NOP_NPC    = 32'h0000_0000;
  localparam logic        FQ_NOP_COMMIT = 1'b0;

endpackage

// File: rtl/fq_ptr.sv
// Wrap-around pointer: increments modulo 2**W, clear wins over increment; result visible the cycle after.
// No backpressure of its own; the caller gates inc_i.
module fq_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  // Power-of-two depth lets the natural carry-out drop provide the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch->decode packet buffer; 1-cycle enqueue-to-head latency, NOP packet presented when empty.
// F_ready_o drops only when full (registered count), so fetch never sees a combinational path from decode stall.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned INSTR_W = FQ_INSTR_WIDTH,
  parameter int unsigned PC_W    = FQ_PC_WIDTH,
  parameter int unsigned DEPTH   = FQ_DEPTH,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FQ_NOP_INSTR),
  parameter logic [PC_W-1:0]    NOP_PC    = PC_W'(FQ_NOP_PC),
  parameter logic [PC_W-1:0]    NOP_NPC   = PC_W'(FQ_NOP_NPC)
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       F_valid_i,
  input  logic [INSTR_W-1:0]         F_instr_i,
  input  logic [PC_W-1:0]            F_PC_i,
  input  logic [PC_W-1:0]            F_nPC_i,
  input  logic                       F_commit_i,
  output logic                       F_ready_o,
  input  logic                       F_bubble_i,
  input  logic                       D_stall_i,
  output logic                       FD_valid_o,
  output logic [INSTR_W-1:0]         FD_instr_o,
  output logic [PC_W-1:0]            FD_PC_o,
  output logic [PC_W-1:0]            FD_nPC_o,
  output logic                       FD_commit_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;

  logic [INSTR_W-1:0] instr_mem  [DEPTH];
  logic [PC_W-1:0]    pc_mem     [DEPTH];
  logic [PC_W-1:0]    npc_mem    [DEPTH];
  logic               commit_mem [DEPTH];

  assign F_ready_o  = (count_q != CW'(DEPTH));
  assign FD_valid_o = (count_q != '0);
  assign enq        = F_valid_i & F_ready_o & ~F_bubble_i;
  assign deq        = FD_valid_o & ~D_stall_i & ~F_bubble_i;
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (F_bubble_i) begin
      count_d = '0;
    end else if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (deq && !enq) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      instr_mem[wr_ptr]  <= F_instr_i;
      pc_mem[wr_ptr]     <= F_PC_i;
      npc_mem[wr_ptr]    <= F_nPC_i;
      commit_mem[wr_ptr] <= F_commit_i;
    end
  end

  fq_ptr #(.W(PW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (F_bubble_i),
    .inc_i (deq),
    .ptr_o (rd_ptr)
  );

  fq_ptr #(.W(PW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clr_i (F_bubble_i),
    .inc_i (enq),
    .ptr_o (wr_ptr)
  );

  always_comb begin
    FD_instr_o  = NOP_INSTR;
    FD_PC_o     = NOP_PC;
    FD_nPC_o    = NOP_NPC;
    FD_commit_o = FQ_NOP_COMMIT;
    if (FD_valid_o) begin
      FD_instr_o  = instr_mem[rd_ptr];
      FD_PC_o     = pc_mem[rd_ptr];
      FD_nPC_o    = npc_mem[rd_ptr];
      FD_commit_o = commit_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4): vector table for fill/drain/wrap/flush plus hand sequences.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        F_valid_i;
  logic [31:0] F_instr_i;
  logic [31:0] F_PC_i;
  logic [31:0] F_nPC_i;
  logic        F_commit_i;
  logic        F_ready_o;
  logic        F_bubble_i;
  logic        D_stall_i;
  logic        FD_valid_o;
  logic [31:0] FD_instr_o;
  logic [31:0] FD_PC_o;
  logic [31:0] FD_nPC_o;
  logic        FD_commit_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  fetch_queue u_dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .F_valid_i   (F_valid_i),
    .F_instr_i   (F_instr_i),
    .F_PC_i      (F_PC_i),
    .F_nPC_i     (F_nPC_i),
    .F_commit_i  (F_commit_i),
    .F_ready_o   (F_ready_o),
    .F_bubble_i  (F_bubble_i),
    .D_stall_i   (D_stall_i),
    .FD_valid_o  (FD_valid_o),
    .FD_instr_o  (FD_instr_o),
    .FD_PC_o     (FD_PC_o),
    .FD_nPC_o    (FD_nPC_o),
    .FD_commit_o (FD_commit_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        bub;
    logic        st;
    int          cnt;
    logic        val;
    logic [31:0] hpc;
    logic        rdy;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic bub, logic st,
                              int cnt, logic val, logic [31:0] hpc, logic rdy);
    vec_t r;
    r.v = v; r.pc = pc; r.bub = bub; r.st = st;
    r.cnt = cnt; r.val = val; r.hpc = hpc; r.rdy = rdy;
    return r;
  endfunction

  // Payload fields are derived from the PC so the head can be checked fully.
  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic bub, logic st);
    F_valid_i  = v;
    F_PC_i     = pc;
    F_instr_i  = instr_of(pc);
    F_nPC_i    = pc + 32'd4;
    F_commit_i = pc[2];
    F_bubble_i = bub;
    D_stall_i  = st;
  endtask

  task automatic chk_head(string tag, logic val, logic [31:0] hpc);
    chk({tag, ".valid"}, 64'(FD_valid_o), 64'(val));
    if (val) begin
      chk({tag, ".pc"},     64'(FD_PC_o),     64'(hpc));
      chk({tag, ".instr"},  64'(FD_instr_o),  64'(instr_of(hpc)));
      chk({tag, ".npc"},    64'(FD_nPC_o),    64'(hpc + 32'd4));
      chk({tag, ".commit"}, 64'(FD_commit_o), 64'(hpc[2]));
    end else begin
      chk({tag, ".pc"},     64'(FD_PC_o),     64'(32'h0));
      chk({tag, ".instr"},  64'(FD_instr_o),  64'(32'h0000_0013));
      chk({tag, ".npc"},    64'(FD_nPC_o),    64'(32'h0));
      chk({tag, ".commit"}, 64'(FD_commit_o), 64'(1'b0));
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #12;
    rst_n = 1'b0;
    #1;
    chk("rst.count", 64'(count_o), 64'(0));
    chk("rst.ready", 64'(F_ready_o), 64'(1));
    chk_head("rst", 1'b0, 32'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle.count", 64'(count_o), 64'(0));

    // fill while stalled, 5th held off, drain across wrap, count=1 enq/deq, flush
    tbl.push_back(mk(1, 32'h100, 0, 1, 1, 1, 32'h100, 1));
    tbl.push_back(mk(1, 32'h104, 0, 1, 2, 1, 32'h100, 1));
    tbl.push_back(mk(1, 32'h108, 0, 1, 3, 1, 32'h100, 1));
    tbl.push_back(mk(1, 32'h10C, 0, 1, 4, 1, 32'h100, 0));
    tbl.push_back(mk(1, 32'h110, 0, 1, 4, 1, 32'h100, 0));
    tbl.push_back(mk(1, 32'h110, 0, 0, 3, 1, 32'h104, 1));
    tbl.push_back(mk(1, 32'h110, 0, 0, 3, 1, 32'h108, 1));
    tbl.push_back(mk(1, 32'h114, 0, 0, 3, 1, 32'h10C, 1));
    tbl.push_back(mk(1, 32'h118, 0, 0, 3, 1, 32'h110, 1));
    tbl.push_back(mk(1, 32'h11C, 0, 0, 3, 1, 32'h114, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 2, 1, 32'h118, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 1, 32'h11C, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 1, 0, 0, 32'h0,   1));
    tbl.push_back(mk(1, 32'h200, 0, 1, 1, 1, 32'h200, 1));
    tbl.push_back(mk(1, 32'h204, 0, 0, 1, 1, 32'h204, 1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(1, 32'h208, 0, 1, 1, 1, 32'h208, 1));
    tbl.push_back(mk(1, 32'h20C, 0, 1, 2, 1, 32'h208, 1));
    tbl.push_back(mk(1, 32'h210, 0, 1, 3, 1, 32'h208, 1));
    tbl.push_back(mk(1, 32'h300, 1, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 0, 0, 0, 32'h0,   1));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(tbl[i].v, tbl[i].pc, tbl[i].bub, tbl[i].st);
      @(posedge clk_i);
      #1;
      chk({tag, ".count"}, 64'(count_o), 64'(tbl[i].cnt));
      chk({tag, ".ready"}, 64'(F_ready_o), 64'(tbl[i].rdy));
      chk_head(tag, tbl[i].val, tbl[i].hpc);
    end

    // empty queue: no same-cycle bypass, head appears only after the edge
    drive(1'b1, 32'h400, 1'b0, 1'b0);
    #2;
    chk("lat.before_valid", 64'(FD_valid_o), 64'(0));
    chk("lat.before_pc", 64'(FD_PC_o), 64'(32'h0));
    @(posedge clk_i);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("lat.after_count", 64'(count_o), 64'(1));
    chk_head("lat.after", 1'b1, 32'h400);

    // asynchronous reset mid-cycle with contents present
    drive(1'b1, 32'h404, 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pre_rst.count", 64'(count_o), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.count", 64'(count_o), 64'(0));
    chk("mid_rst.ready", 64'(F_ready_o), 64'(1));
    chk_head("mid_rst", 1'b0, 32'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst.count", 64'(count_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised multi-entry instruction buffer between the fetch and decode stages. It is the successor to the single-entry F/D pipeline register.
- It decouples fetch from decode stalls. It holds up to DEPTH fetched {instr, PC, nPC, commit} packets in order.
- It presents the oldest packet to decode, or a NOP packet when empty.
- It supports a flush (bubble) that discards all contents in one cycle, e.g. on branch mispredict.

Parameters:
- INSTR_W, 32, instruction width.
- PC_W, 32, PC/nPC width.
- DEPTH, 4, entry count; power of two, >= 2.
- NOP_INSTR, 32'h00000013, instruction presented when empty or after flush (matches `nop_instr).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- F_valid_i  in  1  fetch presents a packet this cycle.
- F_instr_i  in  INSTR_W  fetched instruction.
- F_PC_i  in  PC_W  PC of the instruction.
- F_nPC_i  in  PC_W  predicted next PC.
- F_commit_i  in  1  commit flag of the packet.
- F_ready_o  out  1  queue can accept a packet this cycle.
- F_bubble_i  in  1  flush: discard all entries.
- D_stall_i  in  1  decode cannot consume the head this cycle.
- FD_valid_o  out  1  head packet is real (queue non-empty).
- FD_instr_o  out  INSTR_W  head instruction, or NOP_INSTR.
- FD_PC_o  out  PC_W  head PC, or `nop_PC.
- FD_nPC_o  out  PC_W  head nPC, or `nop_nPC.
- FD_commit_o  out  1  head commit flag, or `nop_commit (0).
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries. rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rst_n=0, async):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Therefore FD_valid_o=0, FD_* = NOP values, F_ready_o=1, count_o=0.
  - Entry storage need not be reset.
- enq = F_valid_i & F_ready_o & ~F_bubble_i.
- deq = FD_valid_o & ~D_stall_i & ~F_bubble_i.
- F_ready_o = (count != DEPTH). Derived from registered count only; no combinational path from D_stall_i.
- FD_valid_o = (count != 0).
- FD_* are combinational reads of entry[rd_ptr] when FD_valid_o=1, else NOP constants.
- Enqueue latency: 1 cycle. A packet written at edge N is visible on FD_* after edge N when the queue was empty. There is no same-cycle bypass from F to FD.
- On the rising edge:
  - F_bubble_i=1 (highest priority): rd_ptr<=0, wr_ptr<=0, count<=0. Any same-cycle enqueue and dequeue are dropped.
  - Otherwise, enq only: entry[wr_ptr]<=F packet, wr_ptr++, count++.
  - Otherwise, deq only: rd_ptr++, count--.
  - Otherwise, enq & deq: write, both pointers advance, count unchanged. Possible at any 0<count<DEPTH.
  - Otherwise: hold all state.
- Full (count=DEPTH): F_ready_o=0. F_valid_i is ignored, even if decode dequeues in that same cycle. Fetch must stall and retry the next cycle.
- Empty (count=0): D_stall_i is irrelevant and the NOP packet is presented. An empty queue with FD_commit_o=0 is equivalent to the old bubble behaviour.
- Pointer wrap: an increment from DEPTH-1 goes to 0. FIFO order is preserved across the wrap.
- Reset mid-operation: all contents are lost immediately and asynchronously, and the outputs become NOP.
- Invariants for the bench: count == (wr_ptr - rd_ptr) mod DEPTH, except count=DEPTH when the pointers are equal and the queue is full. count never exceeds DEPTH and never underflows.

Decomposition:
- `nop_instr, `nop_PC, `nop_nPC and `nop_commit stay in define.v, along with `INSTR_WIDTH and `PC_WIDTH. Add `FQ_DEPTH, default 4, there.
- Parameter defaults reference those macros.
- One sub-module is natural: fq_ptr, a wrap-around pointer counter (inc enable, clear, async reset). It is instantiated twice, for rd_ptr and wr_ptr.
- Storage, count and output muxing stay in fetch_queue.

Test Plan:
- Reset then idle:
  - rst_n=0 mid-cycle -> immediately FD_valid_o=0, FD_instr_o=32'h00000013, FD_commit_o=0, count_o=0, F_ready_o=1.
- Fill to full with decode stalled:
  - DEPTH=4, D_stall_i=1, enqueue PC 0x100,0x104,0x108,0x10C -> count_o=4, F_ready_o=0.
  - A 5th packet (0x110) held on F_valid_i is not accepted.
  - FD_PC_o stays 0x100 throughout.
- Drain in order across pointer wrap:
  - From the full state, release D_stall_i and keep enqueuing 0x110, 0x114... each cycle F_ready_o=1.
  - FD_PC_o sequence is 0x100,0x104,0x108,0x10C,0x110.
  - count_o stays 3 in steady state after the first deq (full blocks the enq on that cycle).
  - No packet is lost or duplicated after the wrap.
- Simultaneous enq/deq at count=1:
  - Head 0x200, enqueue 0x204 with D_stall_i=0 -> next cycle count_o=1, FD_PC_o=0x204.
- Flush priority:
  - count=3, assert F_bubble_i together with F_valid_i (PC 0x300) and D_stall_i=0 -> next cycle count_o=0, FD_valid_o=0, FD_instr_o=NOP.
  - PC 0x300 never appears at FD.
- Empty passthrough latency:
  - Empty queue, enqueue PC 0x400 at edge N -> FD_valid_o=1 and FD_PC_o=0x400 only after edge N, not before.
